// File: rtl/ultrasons_echo_ranger.sv
// ultrasons_echo_ranger: ultrasonic trigger / echo-width ranging core for the Ultrasons register slave.
// Optional echo glitch filter: define ULTRASONS_ECHO_FILTER_EN (FILTER_CYCLES deep).
module ultrasons_echo_ranger #(
    parameter int CNT_W          = 32,
    parameter int TRIG_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 3000000,
    parameter int PERIOD_CYCLES  = 6000000,
    parameter int FILTER_CYCLES  = 4
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             ctrl_enable,
    input  logic             ctrl_single,
    input  logic             echo_in,
    output logic             trig_out,
    output logic             busy,
    output logic [CNT_W-1:0] result_count,
    output logic             result_timeout,
    output logic             result_valid,
    output logic [15:0]      meas_count
);

    localparam logic [31:0]      TRIG_N   = 32'(TRIG_CYCLES);
    localparam logic [31:0]      TMO_N    = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0]      TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      PER_LAST = 32'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] W_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_DONE,
        S_HOLDOFF
    } state_t;

    state_t           state;
    logic             echo_meta;
    logic             echo_sync;
    logic             echo_s;
    logic             echo_s_q;
    logic             echo_rise;
    logic             single_run;
    logic             abort;
    logic [31:0]      tmr;
    logic [31:0]      per_cnt;
    logic [CNT_W-1:0] width_cnt;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be >= 1");
    end
    if (TRIG_CYCLES < 1) begin : g_bad_trig
        $error("TRIG_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must be >= 1");
    end
    if (PERIOD_CYCLES < 1) begin : g_bad_period
        $error("PERIOD_CYCLES must be >= 1");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("FILTER_CYCLES must be >= 1");
    end

    // Two-flop synchroniser for the asynchronous echo input
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            echo_meta <= 1'b0;
            echo_sync <= 1'b0;
        end else begin
            echo_meta <= echo_in;
            echo_sync <= echo_meta;
        end
    end

`ifdef ULTRASONS_ECHO_FILTER_EN
    localparam int            FW        = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);

    logic [FW-1:0] filt_cnt;
    logic          echo_filt;

    // Adopt a new echo level only once it has held for FILTER_CYCLES samples
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            filt_cnt  <= '0;
            echo_filt <= 1'b0;
        end else if (echo_sync == echo_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            filt_cnt  <= '0;
            echo_filt <= echo_sync;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign echo_s = echo_filt;
`else
    assign echo_s = echo_sync;
`endif

    // Previous echo level; a rise needs a genuine 0->1 transition,
    // so an echo already high when waiting starts is never taken as a rise
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            echo_s_q <= 1'b0;
        end else begin
            echo_s_q <= echo_s;
        end
    end

    assign echo_rise = echo_s && !echo_s_q;
    assign abort     = !single_run && !ctrl_enable;

    // Ranging sequencer with registered outputs
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state          <= S_IDLE;
            single_run     <= 1'b0;
            tmr            <= '0;
            per_cnt        <= '0;
            width_cnt      <= '0;
            trig_out       <= 1'b0;
            busy           <= 1'b0;
            result_count   <= '0;
            result_timeout <= 1'b0;
            result_valid   <= 1'b0;
            meas_count     <= '0;
        end else begin
            result_valid <= 1'b0;
            if (per_cnt != '1) begin
                per_cnt <= per_cnt + 32'd1;
            end
            unique case (state)
                S_IDLE: begin
                    if (ctrl_enable || ctrl_single) begin
                        state      <= S_TRIG;
                        busy       <= 1'b1;
                        single_run <= !ctrl_enable;
                        tmr        <= '0;
                        per_cnt    <= '0;
                    end
                end
                S_TRIG: begin
                    if (abort) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        trig_out <= 1'b0;
                    end else if (tmr == TRIG_N) begin
                        state    <= S_WAIT_RISE;
                        trig_out <= 1'b0;
                        tmr      <= '0;
                    end else begin
                        trig_out <= 1'b1;
                        tmr      <= tmr + 32'd1;
                    end
                end
                S_WAIT_RISE: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (echo_rise) begin
                        state     <= S_MEASURE;
                        width_cnt <= W_ONE;
                        tmr       <= 32'd1;
                    end else if (tmr == TMO_LAST) begin
                        state          <= S_DONE;
                        result_valid   <= 1'b1;
                        result_count   <= '0;
                        result_timeout <= 1'b1;
                        meas_count     <= meas_count + 16'd1;
                    end else begin
                        tmr <= tmr + 32'd1;
                    end
                end
                S_MEASURE: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (!echo_s) begin
                        state          <= S_DONE;
                        result_valid   <= 1'b1;
                        result_count   <= width_cnt;
                        result_timeout <= 1'b0;
                        meas_count     <= meas_count + 16'd1;
                    end else if (tmr == TMO_N) begin
                        // still high after a full TIMEOUT_CYCLES window
                        state          <= S_DONE;
                        result_valid   <= 1'b1;
                        result_count   <= '0;
                        result_timeout <= 1'b1;
                        meas_count     <= meas_count + 16'd1;
                    end else begin
                        tmr <= tmr + 32'd1;
                        if (width_cnt != '1) begin
                            width_cnt <= width_cnt + W_ONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_HOLDOFF;
                end
                S_HOLDOFF: begin
                    if (per_cnt >= PER_LAST) begin
                        if (ctrl_enable && !single_run) begin
                            state   <= S_TRIG;
                            tmr     <= '0;
                            per_cnt <= '0;
                        end else begin
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                            single_run <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    trig_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
